cache_control_nway: RTL and testbench
=====================================

// Module: cache_control_nway
// PURPOSE
//  Control FSM for a parametrised WAYS-way set-associative, write-back, write-allocate cache.
//  Sits between the CPU-side request (mem_read/mem_write) and physical memory (pmem_*).
//  Drives per-way tag/valid/dirty/data array enables in the cache datapath.
//  Adds over the 2-way controller: N ways, tree pseudo-LRU, write hits, invalid-way-first victim choice.
// PARAMETERS
//  WAYS   4  associativity; power of two, >= 2
//  WAY_W  $clog2(WAYS)  way-index width (derived; not overridden)
// PORTS
//  clk            in   1        clock
//  rst            in   1        reset, asynchronous, active-high
//  mem_read       in   1        CPU read request, held until mem_resp
//  mem_write      in   1        CPU write request, held until mem_resp
//  mem_resp       out  1        one-cycle completion pulse to CPU
//  pmem_read      out  1        line read request, held until pmem_resp
//  pmem_write     out  1        line write request, held until pmem_resp
//  pmem_resp      in   1        pmem completion pulse
//  hit            in   WAYS     per-way tag match AND valid, indexed set (combinational)
//  valid          in   WAYS     per-way valid bits of indexed set
//  dirty          in   WAYS     per-way dirty bits of indexed set
//  plru_bits      in   WAYS-1   PLRU tree bits of indexed set
//  plru_load      out  1        write plru_next into PLRU array
//  plru_next      out  WAYS-1   updated PLRU tree bits
//  way_sel        out  WAY_W    way selected by datapath read/pmem muxes
//  load_tag       out  WAYS     per-way tag write enable
//  load_valid     out  WAYS     per-way valid write enable; valid_in = 1 implied
//  load_dirty     out  WAYS     per-way dirty write enable
//  dirty_in       out  1        dirty value written
//  data_we        out  WAYS     per-way data line write enable
//  data_src       out  1        0 = line from pmem, 1 = CPU byte-merge (mem_byte_enable, in datapath)
//  pmem_addr_sel  out  1        0 = {cpu tag,index}, 1 = {victim tag,index}
//  load_pmem_wdata out 1        capture victim line into pmem write buffer
// BEHAVIOUR
//  Reset: state=IDLE, victim_q=0; every output 0 while rst high and in IDLE with no request.
//  rst mid-operation: pmem_read/pmem_write drop combinationally; no array write issued.
//  States: IDLE, WRITE_BACK, FILL, FILL_DONE.
//  IDLE, request, hit!=0: hit_way = lowest set bit of hit.
//   - mem_resp=1 same cycle (0-cycle hit latency).
//   - way_sel=hit_way; plru_load=1.
//   - write: data_we[hit_way]=1, data_src=1, load_dirty[hit_way]=1, dirty_in=1.
//   - mem_read and mem_write both high: treated as write.
//  IDLE, request, hit==0: victim = lowest invalid way if ~&valid, else PLRU victim.
//   - victim registered into victim_q.
//   - valid[v]&dirty[v]: go WRITE_BACK; else FILL.
//  WRITE_BACK: way_sel=victim_q, pmem_addr_sel=1, load_pmem_wdata=1, pmem_write=1.
//   - on pmem_resp: go FILL.
//  FILL: way_sel=victim_q, pmem_read=1.
//   - on pmem_resp: load_tag/load_valid/load_dirty/data_we[victim_q]=1, data_src=0, dirty_in=0.
//   - then go FILL_DONE.
//  FILL_DONE: one idle cycle for array read; go IDLE; request then resolves as hit.
//  Request dropped mid-miss: fill still completes; no mem_resp issued.
//  mem_resp is never asserted outside IDLE.
//  PLRU tree: node i has children 2i+1 / 2i+2; leaves are ways in index order.
//   - victim: from root, bit=0 -> left, bit=1 -> right.
//   - update on access to way w: each node on w's path points away (w left -> 1, w right -> 0).
//   - off-path bits unchanged; WAYS=2 degenerates to a single bit.
//  Hit vector with >1 bit set is illegal: lowest index wins; assertion fires.
// STRUCTURE
//  cache_ctrl_pkg: state_t enum; WAY_W helper; plru_victim() and plru_update() functions.
//  Sub-module plru_tree #(WAYS): combinational victim/next-bits from plru_bits and access way.
//  Top: FSM, victim_q register, priority encoders for hit and invalid.
// TESTING (WAYS=4)
//  rst pulsed during WRITE_BACK -> pmem_write=0 same cycle; IDLE next; no load_* asserted.
//  read, hit=4'b0100, plru_bits=3'b000 -> mem_resp=1 same cycle; way_sel=2; plru_next=3'b100.
//  read miss, valid=4'b1011 -> victim 2, no WRITE_BACK; pmem_read held 5 cycles to pmem_resp;
//   then load_tag=4'b0100, FILL_DONE, then mem_resp on hit.
//  write miss, valid=dirty=4'b1111, plru_bits=3'b000 -> victim 0.
//   WRITE_BACK with pmem_addr_sel=1, then FILL, then write hit: data_we=4'b0001, dirty_in=1.
//  write hit way1 -> data_we=4'b0010, load_dirty=4'b0010, dirty_in=1, data_src=1, mem_resp=1.
//  miss, valid=4'b1111, dirty=4'b1110, plru_bits=3'b000 -> victim 0 clean: FILL, no pmem_write.

Source files
------------

// File: rtl/cache_control_nway_pkg.sv
// Shared types and PLRU tree helpers for the N-way cache controller.
// Tree nodes are numbered heap-style (children 2i+1 / 2i+2) and the leaves are ways in index order.
package cache_control_nway_pkg;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, FILL, FILL_DONE} state_t;

  localparam int MAX_LEVELS = 6;
  typedef logic [63:0] plru_vec_t;

  function automatic int way_w(int ways);
    return $clog2(ways);
  endfunction

  function automatic int plru_victim(plru_vec_t bits, int ways);
    int node;
    node = 0;
    for (int l = 0; l < MAX_LEVELS; l++) begin
      if (node < ways - 1) node = bits[node[5:0]] ? 2 * node + 2 : 2 * node + 1;
    end
    return node - (ways - 1);
  endfunction

  // New value of one tree node after an access to 'way': nodes on the leaf-to-root
  // path point at the sibling subtree; every other node keeps its old value.
  function automatic logic plru_node_next(plru_vec_t bits, int ways, int way, int node);
    int   cur;
    logic r;
    cur = way + ways - 1;
    r   = bits[node[5:0]];
    for (int l = 0; l < MAX_LEVELS; l++) begin
      if (cur > 0) begin
        if ((cur - 1) / 2 == node) r = cur[0];
        cur = (cur - 1) / 2;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_control_nway_if.sv
// CPU / pmem handshakes and per-way array controls between controller and datapath.
interface cache_control_nway_if
  import cache_control_nway_pkg::*;
#(
  parameter int WAYS = 4
) ();
  localparam int WAY_W = way_w(WAYS);

  logic             mem_read, mem_write, mem_resp;
  logic             pmem_read, pmem_write, pmem_resp;
  logic [WAYS-1:0]  hit, valid, dirty;
  logic [WAYS-2:0]  plru_bits, plru_next;
  logic             plru_load;
  logic [WAY_W-1:0] way_sel;
  logic [WAYS-1:0]  load_tag, load_valid, load_dirty, data_we;
  logic             dirty_in, data_src, pmem_addr_sel, load_pmem_wdata;

  modport master (
    input  mem_read, mem_write, pmem_resp, hit, valid, dirty, plru_bits,
    output mem_resp, pmem_read, pmem_write, plru_load, plru_next, way_sel,
           load_tag, load_valid, load_dirty, dirty_in, data_we, data_src,
           pmem_addr_sel, load_pmem_wdata
  );

  modport slave (
    output mem_read, mem_write, pmem_resp, hit, valid, dirty, plru_bits,
    input  mem_resp, pmem_read, pmem_write, plru_load, plru_next, way_sel,
           load_tag, load_valid, load_dirty, dirty_in, data_we, data_src,
           pmem_addr_sel, load_pmem_wdata
  );
endinterface

// File: rtl/cache_control_nway_plru_tree.sv
// Combinational tree pseudo-LRU: victim way from the stored bits and the
// updated bits for an access to access_way_i.
module plru_tree
  import cache_control_nway_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  plru_bits_i,
  input  logic [WAY_W-1:0] access_way_i,
  output logic [WAY_W-1:0] victim_o,
  output logic [WAYS-2:0]  plru_next_o
);
  plru_vec_t bits_ext;

  assign bits_ext = plru_vec_t'(plru_bits_i);
  assign victim_o = WAY_W'(plru_victim(bits_ext, WAYS));

  for (genvar n = 0; n < WAYS - 1; n++) begin : g_node
    assign plru_next_o[n] = plru_node_next(bits_ext, WAYS, int'(access_way_i), n);
  end
endmodule

// File: rtl/cache_control_nway.sv
// Control FSM for a WAYS-way set-associative write-back / write-allocate cache.
// Hits complete combinationally in IDLE; misses evict (invalid way first, else PLRU) and refill.
module cache_control_nway
  import cache_control_nway_pkg::*;
#(
  parameter int WAYS = 4
) (
  input logic                  clk,
  input logic                  rst,
  cache_control_nway_if.master bus
);
  localparam int WAY_W = way_w(WAYS);

  state_t           state_q;
  logic [WAY_W-1:0] victim_q, victim_d, hit_way, inv_way, plru_way;
  logic [WAYS-2:0]  plru_next;
  logic [WAYS-1:0]  hit_oh, victim_oh;
  logic             req, any_hit, needs_wb;

  plru_tree #(.WAYS(WAYS), .WAY_W(WAY_W)) u_plru (
    .plru_bits_i  (bus.plru_bits),
    .access_way_i (hit_way),
    .victim_o     (plru_way),
    .plru_next_o  (plru_next)
  );

  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (bus.hit[i])    hit_way = WAY_W'(i);
      if (!bus.valid[i]) inv_way = WAY_W'(i);
    end
  end

  assign req       = bus.mem_read | bus.mem_write;
  assign any_hit   = |bus.hit;
  assign victim_d  = (&bus.valid) ? plru_way : inv_way;
  assign needs_wb  = bus.valid[victim_d] & bus.dirty[victim_d];
  assign hit_oh    = WAYS'(1) << hit_way;
  assign victim_oh = WAYS'(1) << victim_q;

  // Outputs are gated by rst so an in-flight pmem request drops without waiting for a clock.
  always_comb begin
    bus.mem_resp        = 1'b0;
    bus.pmem_read       = 1'b0;
    bus.pmem_write      = 1'b0;
    bus.plru_load       = 1'b0;
    bus.plru_next       = '0;
    bus.way_sel         = '0;
    bus.load_tag        = '0;
    bus.load_valid      = '0;
    bus.load_dirty      = '0;
    bus.dirty_in        = 1'b0;
    bus.data_we         = '0;
    bus.data_src        = 1'b0;
    bus.pmem_addr_sel   = 1'b0;
    bus.load_pmem_wdata = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req && any_hit) begin
            bus.mem_resp  = 1'b1;
            bus.way_sel   = hit_way;
            bus.plru_load = 1'b1;
            bus.plru_next = plru_next;
            if (bus.mem_write) begin
              bus.data_we    = hit_oh;
              bus.data_src   = 1'b1;
              bus.load_dirty = hit_oh;
              bus.dirty_in   = 1'b1;
            end
          end else if (req) begin
            bus.way_sel = victim_d;
          end
        end
        WRITE_BACK: begin
          bus.way_sel         = victim_q;
          bus.pmem_addr_sel   = 1'b1;
          bus.load_pmem_wdata = 1'b1;
          bus.pmem_write      = 1'b1;
        end
        FILL: begin
          bus.way_sel   = victim_q;
          bus.pmem_read = 1'b1;
          if (bus.pmem_resp) begin
            bus.load_tag   = victim_oh;
            bus.load_valid = victim_oh;
            bus.load_dirty = victim_oh;
            bus.data_we    = victim_oh;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !any_hit) begin
            victim_q <= victim_d;
            state_q  <= needs_wb ? WRITE_BACK : FILL;
          end
        end
        WRITE_BACK: if (bus.pmem_resp) state_q <= FILL;
        FILL:       if (bus.pmem_resp) state_q <= FILL_DONE;
        FILL_DONE:  state_q <= IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

  a_hit_onehot: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE && req) |-> $onehot0(bus.hit));
endmodule

// File: tb/tb_cache_control_nway.sv
// Randomized bench for cache_control_nway (WAYS=4) against a range-based PLRU reference model.
module tb_cache_control_nway;
  localparam int W = 4;

  typedef struct packed {
    logic       mem_resp, pmem_read, pmem_write, plru_load;
    logic [2:0] plru_next;
    logic [1:0] way_sel;
    logic [3:0] load_tag, load_valid, load_dirty;
    logic       dirty_in;
    logic [3:0] data_we;
    logic       data_src, pmem_addr_sel, load_pmem_wdata;
  } outs_t;

  typedef struct {
    logic [3:0] valid, dirty;
    logic [2:0] plru;
    bit         wr;
    int         ev, lat_wb, lat_fill;
  } miss_t;

  logic  clk, rst;
  int    total = 0, bad = 0;
  outs_t obs;

  cache_control_nway_if #(.WAYS(W)) bus ();
  cache_control_nway #(.WAYS(W)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  assign obs = {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.plru_load, bus.plru_next,
                bus.way_sel, bus.load_tag, bus.load_valid, bus.load_dirty, bus.dirty_in,
                bus.data_we, bus.data_src, bus.pmem_addr_sel, bus.load_pmem_wdata};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaf range of tree node i: leaves [lo, lo+2*half), left subtree [lo, lo+half).
  function automatic void node_range(int i, output int lo, output int half);
    int d, span;
    d = 0;
    while ((1 << (d + 1)) - 1 <= i) d++;
    span = W >> d;
    lo   = (i - ((1 << d) - 1)) * span;
    half = span / 2;
  endfunction

  function automatic int model_victim(logic [2:0] bits);
    int lo, half;
    bit ok;
    for (int w = 0; w < W; w++) begin
      ok = 1;
      for (int i = 0; i < W - 1; i++) begin
        node_range(i, lo, half);
        if (w >= lo && w < lo + 2 * half && ((w < lo + half) == bits[i])) ok = 0;
      end
      if (ok) return w;
    end
    return -1;
  endfunction

  function automatic logic [2:0] model_update(logic [2:0] bits, int w);
    int lo, half;
    logic [2:0] nb;
    nb = bits;
    for (int i = 0; i < W - 1; i++) begin
      node_range(i, lo, half);
      if (w >= lo && w < lo + 2 * half) nb[i] = (w < lo + half);
    end
    return nb;
  endfunction

  function automatic int model_choose(logic [3:0] valid, logic [2:0] bits);
    for (int w = 0; w < W; w++) if (!valid[w]) return w;
    return model_victim(bits);
  endfunction

  task automatic test_reset();
    outs_t exp;
    exp = '0;
    #3;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_outs got=%h exp=%h", obs, exp); end
    tick();
    rst = 1'b0;
    #2;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL post_reset_idle got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_read_hit();
    outs_t exp;
    tick();
    bus.mem_read = 1'b1; bus.hit = 4'b0100; bus.valid = 4'b1111; bus.plru_bits = 3'b000;
    #2;
    exp = '0;
    exp.mem_resp = 1'b1; exp.way_sel = 2'd2; exp.plru_load = 1'b1; exp.plru_next = 3'b100;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL read_hit_w2 got=%h exp=%h", obs, exp); end
    tick();
    bus.mem_read = 1'b0; bus.hit = '0;
  endtask

  task automatic test_random_hits();
    outs_t exp;
    int w;
    bit wr;
    logic [2:0] bits;
    for (int k = 0; k < 30; k++) begin
      w    = $urandom_range(0, W - 1);
      wr   = 1'($urandom_range(0, 1));
      bits = 3'($urandom);
      bus.mem_write = wr;
      bus.mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.hit       = 4'b0001 << w;
      bus.valid     = 4'($urandom) | (4'b0001 << w);
      bus.dirty     = 4'($urandom);
      bus.plru_bits = bits;
      #2;
      exp = '0;
      exp.mem_resp = 1'b1; exp.way_sel = 2'(w); exp.plru_load = 1'b1;
      exp.plru_next = model_update(bits, w);
      if (wr) begin
        exp.data_we = 4'b0001 << w; exp.load_dirty = 4'b0001 << w;
        exp.dirty_in = 1'b1; exp.data_src = 1'b1;
      end
      total++;
      if (obs !== exp) begin bad++; $display("FAIL hit%0d got=%h exp=%h", k, obs, exp); end
      tick();
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.hit = '0;
  endtask

  task automatic test_miss_sequences();
    miss_t tbl[$];
    miss_t e;
    outs_t exp;
    int ev;
    bit wb;
    logic [14:0] quiet;
    tbl.push_back('{4'b1011, 4'($urandom), 3'($urandom), 1'b0, 2, 1, 5});
    tbl.push_back('{4'b1111, 4'b1111, 3'b000, 1'b1, 0, 3, 2});
    tbl.push_back('{4'b1111, 4'b1110, 3'b000, 1'b0, 0, 1, 2});
    for (int r = 0; r < 8; r++)
      tbl.push_back('{4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom_range(0, 1)), -1,
                      $urandom_range(1, 4), $urandom_range(1, 4)});
    foreach (tbl[k]) begin
      e  = tbl[k];
      ev = (e.ev >= 0) ? e.ev : model_choose(e.valid, e.plru);
      wb = e.valid[ev] & e.dirty[ev];
      bus.mem_write = e.wr; bus.mem_read = !e.wr; bus.hit = '0;
      bus.valid = e.valid; bus.dirty = e.dirty; bus.plru_bits = e.plru;
      #2;
      quiet = {obs.mem_resp, obs.pmem_read, obs.pmem_write, obs.load_tag, obs.data_we, obs.load_dirty};
      total++;
      if (quiet !== '0) begin bad++; $display("FAIL miss%0d_idle got=%h exp=0", k, quiet); end
      tick();
      if (wb) begin
        for (int c = 1; c <= e.lat_wb; c++) begin
          bus.pmem_resp = (c == e.lat_wb);
          #2;
          exp = '0;
          exp.pmem_write = 1'b1; exp.pmem_addr_sel = 1'b1; exp.load_pmem_wdata = 1'b1;
          exp.way_sel = 2'(ev);
          total++;
          if (obs !== exp) begin bad++; $display("FAIL miss%0d_wb%0d got=%h exp=%h", k, c, obs, exp); end
          tick();
        end
      end
      for (int c = 1; c <= e.lat_fill; c++) begin
        bus.pmem_resp = (c == e.lat_fill);
        #2;
        exp = '0;
        exp.pmem_read = 1'b1; exp.way_sel = 2'(ev);
        if (c == e.lat_fill) begin
          exp.load_tag = 4'b0001 << ev; exp.load_valid = 4'b0001 << ev;
          exp.load_dirty = 4'b0001 << ev; exp.data_we = 4'b0001 << ev;
        end
        total++;
        if (obs !== exp) begin bad++; $display("FAIL miss%0d_fill%0d got=%h exp=%h", k, c, obs, exp); end
        tick();
      end
      bus.pmem_resp = 1'b0;
      bus.hit   = 4'b0001 << ev;
      bus.valid = e.valid | (4'b0001 << ev);
      #2;
      exp = '0;
      total++;
      if (obs !== exp) begin bad++; $display("FAIL miss%0d_filldone got=%h exp=%h", k, obs, exp); end
      tick();
      #2;
      exp = '0;
      exp.mem_resp = 1'b1; exp.way_sel = 2'(ev); exp.plru_load = 1'b1;
      exp.plru_next = model_update(e.plru, ev);
      if (e.wr) begin
        exp.data_we = 4'b0001 << ev; exp.load_dirty = 4'b0001 << ev;
        exp.dirty_in = 1'b1; exp.data_src = 1'b1;
      end
      total++;
      if (obs !== exp) begin bad++; $display("FAIL miss%0d_rehit got=%h exp=%h", k, obs, exp); end
      tick();
      bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.hit = '0;
    end
  endtask

  task automatic test_drop_request();
    outs_t exp;
    bus.mem_read = 1'b1; bus.hit = '0; bus.valid = 4'b0111; bus.dirty = 4'b1111;
    bus.plru_bits = 3'($urandom);
    tick();
    bus.mem_read = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      bus.pmem_resp = (c == 3);
      #2;
      exp = '0;
      exp.pmem_read = 1'b1; exp.way_sel = 2'd3;
      if (c == 3) begin
        exp.load_tag = 4'b1000; exp.load_valid = 4'b1000; exp.load_dirty = 4'b1000; exp.data_we = 4'b1000;
      end
      total++;
      if (obs !== exp) begin bad++; $display("FAIL drop_fill%0d got=%h exp=%h", c, obs, exp); end
      tick();
    end
    bus.pmem_resp = 1'b0;
    bus.hit = 4'b1000; bus.valid = 4'b1111;
    tick();
    #2;
    exp = '0;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL drop_no_resp got=%h exp=%h", obs, exp); end
    bus.hit = '0;
  endtask

  task automatic test_rst_mid_writeback();
    outs_t exp;
    int ev;
    tick();
    bus.mem_write = 1'b1; bus.hit = '0; bus.valid = 4'b1111; bus.dirty = 4'b1111;
    bus.plru_bits = 3'b111;
    ev = model_choose(4'b1111, 3'b111);
    tick();
    #2;
    total++;
    if ({bus.pmem_write, bus.way_sel} !== {1'b1, 2'(ev)}) begin
      bad++; $display("FAIL rst_wb_entry got=%b exp=%b", {bus.pmem_write, bus.way_sel}, {1'b1, 2'(ev)});
    end
    rst = 1'b1;
    #1;
    exp = '0;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL rst_wb_drop got=%h exp=%h", obs, exp); end
    tick();
    rst = 1'b0; bus.mem_write = 1'b0;
    #2;
    total++;
    if (obs !== exp) begin bad++; $display("FAIL rst_idle got=%h exp=%h", obs, exp); end
    bus.mem_read = 1'b1; bus.hit = 4'b0001;
    #1;
    total++;
    if (bus.mem_resp !== 1'b1) begin bad++; $display("FAIL rst_then_hit got=%b exp=1", bus.mem_resp); end
    tick();
    bus.mem_read = 1'b0; bus.hit = '0;
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
    bus.hit = '0; bus.valid = '0; bus.dirty = '0; bus.plru_bits = '0;
    test_reset();
    test_read_hit();
    test_random_hits();
    test_miss_sequences();
    test_drop_request();
    test_rst_mid_writeback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
